// File: rtl/landscape_sweep_ctrl_pkg.sv
// Shared types and defaults for the landscape sampling run controller.
// Holds the run-state encoding and the default widths used by the top and its tracker.
package landscape_pkg;

    localparam int BIT_ADDR_DEF = 9;
    localparam int CNT_W_DEF    = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/landscape_sweep_ctrl_if.sv
// Sweep read-address handshake between the run controller and the landscape readout.
// master drives address/valid/last, slave returns ready.
interface landscape_sweep_ctrl_if #(
    parameter int bit_addr = 9
) ();

    logic [bit_addr-1:0] rd_addr;
    logic                rd_valid;
    logic                rd_ready;
    logic                rd_last;

    modport master (
        output rd_addr,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_addr,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );

endinterface

// File: rtl/landscape_sweep_ctrl_addr_max_track.sv
// Tracks the highest accepted event address and a saturating event count for one run.
// seen distinguishes "no events yet" from "address 0 was hit".
module addr_max_track #(
    parameter int bit_addr = 9,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                clear,
    input  logic                en,
    input  logic [bit_addr-1:0] addr,
    output logic                seen,
    output logic [bit_addr-1:0] addr_fin,
    output logic [CNT_W-1:0]    evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                seen_r;
    logic [bit_addr-1:0] addr_fin_r;
    logic [CNT_W-1:0]    evt_cnt_r;

    // seen flag, running maximum and saturating counter
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seen_r     <= 1'b0;
            addr_fin_r <= {bit_addr{1'b0}};
            evt_cnt_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            seen_r     <= 1'b0;
            addr_fin_r <= {bit_addr{1'b0}};
            evt_cnt_r  <= {CNT_W{1'b0}};
        end else if (en) begin
            seen_r <= 1'b1;
            if (!seen_r || (addr > addr_fin_r)) begin
                addr_fin_r <= addr;
            end else begin
                addr_fin_r <= addr_fin_r;
            end
            if (evt_cnt_r != CNT_SAT) begin
                evt_cnt_r <= evt_cnt_r + CNT_ONE;
            end else begin
                evt_cnt_r <= evt_cnt_r;
            end
        end else begin
            seen_r     <= seen_r;
            addr_fin_r <= addr_fin_r;
            evt_cnt_r  <= evt_cnt_r;
        end
    end

    assign seen     = seen_r;
    assign addr_fin = addr_fin_r;
    assign evt_cnt  = evt_cnt_r;

endmodule

// File: rtl/landscape_sweep_ctrl.sv
// Landscape sampling run sequencer: acquire address events while the window is open,
// then sweep read addresses 0..addr_fin to the readout, then pulse done.
module landscape_sweep_ctrl
    import landscape_pkg::*;
#(
    parameter int bit_addr = BIT_ADDR_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ae,
    input  logic [bit_addr-1:0]    addr,
    input  logic                   exp_w1_de1,
    landscape_sweep_ctrl_if.master rd,
    output logic                   busy,
    output logic                   done,
    output logic                   empty,
    output logic [bit_addr-1:0]    addr_fin,
    output logic [CNT_W-1:0]       evt_cnt
);

    localparam logic [bit_addr-1:0] ADDR_ZERO = {bit_addr{1'b0}};
    localparam logic [bit_addr-1:0] ADDR_ONE  = {{(bit_addr-1){1'b0}}, 1'b1};

    state_e              state_r;
    state_e              next_state_s;
    logic                exp_q_r;
    logic                close_evt_s;
    logic                run_clear_s;
    logic                evt_acc_s;
    logic                seen_s;
    logic [bit_addr-1:0] addr_fin_s;
    logic                xfer_s;
    logic                last_s;

    logic [bit_addr-1:0] rd_addr_r;
    logic [bit_addr-1:0] rd_addr_nx_s;
    logic                rd_valid_r;
    logic                rd_valid_nx_s;
    logic                empty_r;
    logic                empty_nx_s;
    logic                busy_r;
    logic                busy_nx_s;
    logic                done_r;
    logic                done_nx_s;

    // window-close edge detect; a window already closed at ACQ entry needs a fresh rise
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            exp_q_r <= 1'b0;
        end else begin
            exp_q_r <= exp_w1_de1;
        end
    end

    assign close_evt_s = exp_w1_de1 & ~exp_q_r;
    assign run_clear_s = (state_r == ST_IDLE) & start & ~abort;
    assign evt_acc_s   = (state_r == ST_ACQ) & ae & ~exp_w1_de1 & ~abort;
    assign xfer_s      = rd_valid_r & rd.rd_ready;
    assign last_s      = rd_valid_r & (rd_addr_r == addr_fin_s);

    addr_max_track #(
        .bit_addr (bit_addr),
        .CNT_W    (CNT_W)
    ) u_track (
        .clk      (clk),
        .clr_n    (clr_n),
        .clear    (run_clear_s),
        .en       (evt_acc_s),
        .addr     (addr),
        .seen     (seen_s),
        .addr_fin (addr_fin_s),
        .evt_cnt  (evt_cnt)
    );

    // state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state decode; abort overrides every transition
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_ACQ;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_ACQ: begin
                    if (close_evt_s) begin
                        if (seen_s) begin
                            next_state_s = ST_SWEEP;
                        end else begin
                            next_state_s = ST_DONE;
                        end
                    end else begin
                        next_state_s = ST_ACQ;
                    end
                end
                ST_SWEEP: begin
                    if (xfer_s && last_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SWEEP;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // next values of the registered outputs
    always_comb begin
        rd_addr_nx_s  = rd_addr_r;
        rd_valid_nx_s = rd_valid_r;
        empty_nx_s    = empty_r;
        busy_nx_s     = (next_state_s != ST_IDLE);
        done_nx_s     = (next_state_s == ST_DONE);
        if (abort) begin
            rd_valid_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        empty_nx_s = 1'b0;
                    end else begin
                        empty_nx_s = empty_r;
                    end
                end
                ST_ACQ: begin
                    if (close_evt_s && seen_s) begin
                        rd_addr_nx_s  = ADDR_ZERO;
                        rd_valid_nx_s = 1'b1;
                    end else if (close_evt_s) begin
                        empty_nx_s = 1'b1;
                    end else begin
                        rd_valid_nx_s = 1'b0;
                    end
                end
                ST_SWEEP: begin
                    // addr_fin never exceeds the address range, so last always fires before wrap
                    if (xfer_s && last_s) begin
                        rd_valid_nx_s = 1'b0;
                    end else if (xfer_s) begin
                        rd_addr_nx_s = rd_addr_r + ADDR_ONE;
                    end else begin
                        rd_addr_nx_s = rd_addr_r;
                    end
                end
                ST_DONE: begin
                    rd_valid_nx_s = 1'b0;
                end
                default: begin
                    rd_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rd_addr_r  <= ADDR_ZERO;
            rd_valid_r <= 1'b0;
            empty_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_addr_r  <= rd_addr_nx_s;
            rd_valid_r <= rd_valid_nx_s;
            empty_r    <= empty_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
        end
    end

    assign rd.rd_addr  = rd_addr_r;
    assign rd.rd_valid = rd_valid_r;
    assign rd.rd_last  = last_s;
    assign busy        = busy_r;
    assign done        = done_r;
    assign empty       = empty_r;
    assign addr_fin    = addr_fin_s;

endmodule
